// File: rtl/cvxif_copro_responder.sv
// CV-X-IF responder for the example coprocessor: decodes custom-3 ADD/NOP/MUL,
// executes them and returns results in order through a small result FIFO.
module cvxif_copro_responder #(
   parameter int XLEN        = 32,
   parameter int X_ID_WIDTH  = 4,
   parameter int HART_W      = 1,
   parameter int RES_DEPTH   = 4,
   parameter int MUL_LATENCY = 3
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  issue_valid_i,
   output logic                  issue_ready_o,
   input  logic [31:0]           issue_instr_i,
   input  logic [HART_W-1:0]     issue_hartid_i,
   input  logic [X_ID_WIDTH-1:0] issue_id_i,
   input  logic [XLEN-1:0]       issue_rs1_i,
   input  logic [XLEN-1:0]       issue_rs2_i,
   output logic                  issue_accept_o,
   output logic                  issue_writeback_o,
   output logic                  result_valid_o,
   input  logic                  result_ready_i,
   output logic [HART_W-1:0]     result_hartid_o,
   output logic [X_ID_WIDTH-1:0] result_id_o,
   output logic [4:0]            result_rd_o,
   output logic                  result_we_o,
   output logic [XLEN-1:0]       result_data_o
);

   localparam logic [6:0] OPC_CUSTOM3 = 7'b1111011;
   localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int LAT_W = $clog2(MUL_LATENCY + 1);

   typedef struct packed {
      logic [HART_W-1:0]     hartid;
      logic [X_ID_WIDTH-1:0] id;
      logic [4:0]            rd;
      logic                  we;
      logic [XLEN-1:0]       data;
   } res_t;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t state_q, state_d;

   logic             dec_valid, dec_mul, dec_we;
   logic [2:0]       funct3;
   logic             issue_hs;
   logic [XLEN-1:0]  add_sum;
   logic             unused_instr_bits;

   logic [XLEN-1:0]       mul_a, mul_b;
   logic [HART_W-1:0]     mul_hartid;
   logic [X_ID_WIDTH-1:0] mul_id;
   logic [4:0]            mul_rd;
   logic [XLEN-1:0]       mul_prod;
   logic [LAT_W-1:0]      cnt_q;
   logic                  mul_start;

   res_t             fifo_mem [RES_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push, pop, res_show;
   res_t             push_entry, head;

   // ---------------------------------------------------------------- decode
   assign funct3            = issue_instr_i[14:12];
   assign unused_instr_bits = ^issue_instr_i[24:15];

   always_comb begin
      dec_valid = 1'b0;
      dec_mul   = 1'b0;
      dec_we    = 1'b0;
      if (issue_instr_i[6:0] == OPC_CUSTOM3 && issue_instr_i[31:25] == 7'd0) begin
         case (funct3)
            3'b000: begin dec_valid = 1'b1; dec_we = 1'b1; end
            3'b001: begin dec_valid = 1'b1; end
            3'b010: begin dec_valid = 1'b1; dec_we = 1'b1; dec_mul = 1'b1; end
            default: ;
         endcase
      end
   end

   assign issue_accept_o    = dec_valid;
   assign issue_writeback_o = dec_we;

   // Reset gates ready combinationally so nothing is taken in the reset cycle.
   assign issue_ready_o = !rst_i && (state_q == IDLE) && (count < CNT_W'(RES_DEPTH));
   assign issue_hs      = issue_valid_i && issue_ready_o;
   assign add_sum       = issue_rs1_i + issue_rs2_i;
   assign mul_prod      = mul_a * mul_b;

   // ------------------------------------------------------------ exec FSM
   always_comb begin
      state_d    = state_q;
      push       = 1'b0;
      mul_start  = 1'b0;
      push_entry = '0;
      case (state_q)
         IDLE: begin
            if (issue_hs && dec_valid) begin
               if (dec_mul) begin
                  mul_start = 1'b1;
                  state_d   = BUSY;
               end else begin
                  push              = 1'b1;
                  push_entry.hartid = issue_hartid_i;
                  push_entry.id     = issue_id_i;
                  push_entry.rd     = issue_instr_i[11:7];
                  push_entry.we     = dec_we;
                  push_entry.data   = dec_we ? add_sum : '0;
               end
            end
         end
         BUSY: begin
            if (cnt_q == LAT_W'(1)) begin
               push              = 1'b1;
               push_entry.hartid = mul_hartid;
               push_entry.id     = mul_id;
               push_entry.rd     = mul_rd;
               push_entry.we     = 1'b1;
               push_entry.data   = mul_prod;
               state_d           = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         mul_a      <= '0;
         mul_b      <= '0;
         mul_hartid <= '0;
         mul_id     <= '0;
         mul_rd     <= '0;
      end else begin
         state_q <= state_d;
         if (mul_start) begin
            cnt_q      <= LAT_W'(MUL_LATENCY - 1);
            mul_a      <= issue_rs1_i;
            mul_b      <= issue_rs2_i;
            mul_hartid <= issue_hartid_i;
            mul_id     <= issue_id_i;
            mul_rd     <= issue_instr_i[11:7];
         end else if (state_q == BUSY) begin
            cnt_q <= cnt_q - LAT_W'(1);
         end
      end
   end

   // ---------------------------------------------------------- result FIFO
   // The MUL accept already required a free slot and nothing else pushes while
   // BUSY, so the completion push can never overflow.
   assign res_show       = !rst_i && (count != '0);
   assign pop            = res_show && result_ready_i;
   assign head           = res_show ? fifo_mem[rd_ptr] : '0;
   assign result_valid_o  = res_show;
   assign result_hartid_o = head.hartid;
   assign result_id_o     = head.id;
   assign result_rd_o     = head.rd;
   assign result_we_o     = head.we;
   assign result_data_o   = head.data;

   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_ptr] <= push_entry;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Randomised scoreboard bench for cvxif_copro_responder: the stimulus side
// predicts results from the instruction rules, a monitor checks the result port.
module tb_cvxif_copro_responder;

   localparam logic [6:0] C3 = 7'b1111011;
   localparam int MUL_L = 3;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        issue_valid_i, issue_ready_o;
   logic [31:0] issue_instr_i;
   logic [0:0]  issue_hartid_i;
   logic [3:0]  issue_id_i;
   logic [31:0] issue_rs1_i, issue_rs2_i;
   logic        issue_accept_o, issue_writeback_o;
   logic        result_valid_o, result_ready_i;
   logic [0:0]  result_hartid_o;
   logic [3:0]  result_id_o;
   logic [4:0]  result_rd_o;
   logic        result_we_o;
   logic [31:0] result_data_o;

   typedef struct {
      logic [0:0]  hartid;
      logic [3:0]  id;
      logic [4:0]  rd;
      logic        we;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   vectors = 0, miscompares = 0;
   int   cyc = 0;

   cvxif_copro_responder dut (
      .clk_i(clk), .rst_i(rst_i),
      .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
      .issue_instr_i(issue_instr_i), .issue_hartid_i(issue_hartid_i),
      .issue_id_i(issue_id_i), .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
      .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
      .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
      .result_hartid_o(result_hartid_o), .result_id_o(result_id_o),
      .result_rd_o(result_rd_o), .result_we_o(result_we_o),
      .result_data_o(result_data_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                      input logic [4:0] rd, input logic [6:0] op);
      logic [9:0] rs = 10'($urandom);
      return {f7, rs, f3, rd, op};
   endfunction

   // Reference behaviour straight from the instruction rules.
   function automatic void ref_model(input logic [31:0] ins, input logic [31:0] a, b,
                                     output bit acc, output bit wb, output logic [31:0] d);
      logic [63:0] p;
      acc = 0; wb = 0; d = 32'd0;
      if (ins[6:0] == C3 && ins[31:25] == 7'd0) begin
         case (ins[14:12])
            3'd0: begin acc = 1; wb = 1; d = a + b; end
            3'd1: begin acc = 1; end
            3'd2: begin acc = 1; wb = 1; p = 64'(a) * 64'(b); d = p[31:0]; end
            default: ;
         endcase
      end
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic send(input logic [31:0] ins, input logic [0:0] hart, input logic [3:0] id,
                       input logic [31:0] a, b, input bit rnd_rdy, output int hs);
      bit acc, wb;
      logic [31:0] d;
      int w = 0;
      hs = -1;
      issue_valid_i = 1; issue_instr_i = ins; issue_hartid_i = hart;
      issue_id_i = id; issue_rs1_i = a; issue_rs2_i = b;
      forever begin
         @(negedge clk);
         if (issue_ready_o) break;
         if (++w > 200) break;
         @(posedge clk); #1;
         if (rnd_rdy) result_ready_i = 1'($urandom_range(0, 1));
      end
      if (w > 200) begin
         chk("issue_handshake_timeout", 64'd0, 64'd1);
      end else begin
         hs = cyc;
         ref_model(ins, a, b, acc, wb, d);
         chk("issue_accept", 64'(issue_accept_o), 64'(acc));
         chk("issue_writeback", 64'(issue_writeback_o), 64'(wb));
         if (acc) exp_q.push_back('{hart, id, ins[11:7], wb, d});
      end
      @(posedge clk); #1;
      issue_valid_i = 0;
      if (rnd_rdy) result_ready_i = 1'($urandom_range(0, 1));
   endtask

   task automatic wait_valid(input int exp_cyc, input string nm);
      int w = 0;
      forever begin
         @(negedge clk);
         if (result_valid_o) break;
         if (++w > 50) break;
      end
      chk(nm, 64'(cyc), 64'(exp_cyc));
   endtask

   task automatic drain();
      int w = 0;
      step();
      result_ready_i = 1;
      forever begin
         @(negedge clk);
         if (exp_q.size() == 0 && !result_valid_o) break;
         if (++w > 100) break;
      end
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
      step();
   endtask

   // Scoreboard monitor: the head must match the oldest outstanding prediction
   // on every valid cycle, stalled or not; it is retired only on a pop.
   always @(negedge clk) begin
      if (!rst_i && result_valid_o) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result_id", 64'(result_id_o), 64'hdead);
         end else begin
            mon_e = exp_q[0];
            chk("result_id", 64'(result_id_o), 64'(mon_e.id));
            chk("result_hartid", 64'(result_hartid_o), 64'(mon_e.hartid));
            chk("result_rd", 64'(result_rd_o), 64'(mon_e.rd));
            chk("result_we", 64'(result_we_o), 64'(mon_e.we));
            chk("result_data", 64'(result_data_o), 64'(mon_e.data));
            if (result_ready_i) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      int hs, hs_b[5], pop_cyc, kind;
      logic [31:0] ins;
      logic [6:0]  op;
      rst_i = 1; issue_valid_i = 0; issue_instr_i = 0; issue_hartid_i = 0;
      issue_id_i = 0; issue_rs1_i = 0; issue_rs2_i = 0; result_ready_i = 0;

      // reset values
      repeat (2) step();
      @(negedge clk);
      chk("rst_issue_ready", 64'(issue_ready_o), 64'd0);
      chk("rst_result_valid", 64'(result_valid_o), 64'd0);
      chk("rst_result_data", 64'(result_data_o), 64'd0);
      chk("rst_result_id", 64'(result_id_o), 64'd0);
      step();
      rst_i = 0;
      @(negedge clk);
      chk("post_rst_issue_ready", 64'(issue_ready_o), 64'd1);
      chk("post_rst_result_valid", 64'(result_valid_o), 64'd0);
      step();

      // ADD, latency 1, wrapping sum
      result_ready_i = 1;
      send(mk(7'd0, 3'd0, 5'd7, C3), 1'b1, 4'd3, 32'h0000_0005, 32'hFFFF_FFFE, 0, hs);
      wait_valid(hs + 1, "add_latency");
      drain();

      // MUL, latency 3, ready low while busy
      send(mk(7'd0, 3'd2, 5'd9, C3), 1'b0, 4'd2, 32'h0001_0000, 32'h0001_0003, 0, hs);
      @(negedge clk); chk("mul_busy_ready_n1", 64'(issue_ready_o), 64'd0);
      @(negedge clk); chk("mul_busy_ready_n2", 64'(issue_ready_o), 64'd0);
      wait_valid(hs + MUL_L, "mul_latency");
      drain();

      // rejects, then NOP
      send(mk(7'd0, 3'd0, 5'd4, 7'b0110011), 1'b0, 4'd1, 32'd1, 32'd2, 0, hs);
      send(mk(7'd0, 3'd3, 5'd4, C3), 1'b1, 4'd1, 32'd1, 32'd2, 0, hs);
      send(mk(7'd1, 3'd0, 5'd4, C3), 1'b1, 4'd1, 32'd1, 32'd2, 0, hs);
      repeat (2) begin
         @(negedge clk);
         chk("reject_no_result", 64'(result_valid_o), 64'd0);
         chk("reject_fifo_empty_ready", 64'(issue_ready_o), 64'd1);
      end
      step();
      send(mk(7'd0, 3'd1, 5'd12, C3), 1'b0, 4'd5, 32'h1234, 32'h5678, 0, hs);
      wait_valid(hs + 1, "nop_latency");
      drain();

      // backpressure: four fill the FIFO, the fifth waits for the first pop
      result_ready_i = 0;
      for (int i = 0; i < 4; i++) begin
         send(mk(7'd0, 3'd0, 5'(i + 1), C3), 1'(i), 4'(i), $urandom, $urandom, 0, hs_b[i]);
         if (i > 0) chk("bp_back_to_back", 64'(hs_b[i]), 64'(hs_b[0] + i));
      end
      fork
         send(mk(7'd0, 3'd0, 5'd20, C3), 1'b0, 4'd4, $urandom, $urandom, 0, hs_b[4]);
         begin
            repeat (3) begin
               @(negedge clk);
               chk("bp_full_ready", 64'(issue_ready_o), 64'd0);
            end
            @(posedge clk); #1;
            result_ready_i = 1;
            @(negedge clk);
            pop_cyc = cyc;
            chk("bp_ready_in_pop_cycle", 64'(issue_ready_o), 64'd0);
         end
      join
      chk("bp_fifth_after_pop", 64'(hs_b[4]), 64'(pop_cyc + 1));
      drain();

      // push and pop together at 3 entries keeps count at 3
      result_ready_i = 0;
      for (int i = 0; i < 3; i++)
         send(mk(7'd0, 3'd0, 5'd3, C3), 1'b1, 4'(8 + i), $urandom, $urandom, 0, hs_b[i]);
      result_ready_i = 1;
      send(mk(7'd0, 3'd0, 5'd5, C3), 1'b0, 4'd11, $urandom, $urandom, 0, hs_b[3]);
      result_ready_i = 0;
      chk("simul_push_pop_hs", 64'(hs_b[3]), 64'(hs_b[2] + 1));
      send(mk(7'd0, 3'd0, 5'd6, C3), 1'b1, 4'd12, $urandom, $urandom, 0, hs_b[4]);
      chk("simul_next_hs", 64'(hs_b[4]), 64'(hs_b[3] + 1));
      @(negedge clk);
      chk("simul_now_full", 64'(issue_ready_o), 64'd0);
      drain();

      // random mix with random backpressure, exercises pointer wrap
      for (int n = 0; n < 48; n++) begin
         kind = $urandom_range(0, 7);
         op = C3;
         case (kind)
            0, 1: ins = mk(7'd0, 3'd0, 5'($urandom), C3);
            2:    ins = mk(7'd0, 3'd1, 5'($urandom), C3);
            3, 4: ins = mk(7'd0, 3'd2, 5'($urandom), C3);
            5:    ins = mk(7'd0, 3'($urandom_range(3, 7)), 5'($urandom), C3);
            6:    begin
                     op = 7'($urandom);
                     if (op == C3) op = 7'b0110011;
                     ins = mk(7'd0, 3'($urandom_range(0, 2)), 5'($urandom), op);
                  end
            default: ins = mk(7'($urandom_range(1, 127)), 3'd0, 5'($urandom), C3);
         endcase
         send(ins, 1'($urandom), 4'($urandom), $urandom, $urandom, 1, hs);
         if ($urandom_range(0, 3) == 0) step();
      end
      drain();

      // reset while a MUL is in flight discards it
      send(mk(7'd0, 3'd2, 5'd10, C3), 1'b1, 4'd6, 32'd7, 32'd9, 0, hs);
      rst_i = 1;
      exp_q.delete();
      @(negedge clk);
      chk("mid_rst_issue_ready", 64'(issue_ready_o), 64'd0);
      chk("mid_rst_result_valid", 64'(result_valid_o), 64'd0);
      step();
      rst_i = 0;
      repeat (5) begin
         @(negedge clk);
         chk("rst_mul_discarded", 64'(result_valid_o), 64'd0);
         chk("rst_mul_idle_ready", 64'(issue_ready_o), 64'd1);
      end
      step();
      send(mk(7'd0, 3'd0, 5'd11, C3), 1'b0, 4'd7, 32'hFFFF_FFFF, 32'h0000_0002, 0, hs);
      wait_valid(hs + 1, "post_rst_add_latency");
      drain();

      chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
